// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command constants and helpers for the LCD frame writer.
// Optional build macro LCD_NUL_AS_SPACE_EN is consumed by lcd_byte_strobe.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        LATCH,
        SEND_ADDR,
        SEND_CHAR,
        FINISH
    } lcd_state_t;

    typedef enum logic [1:0] {
        STB_IDLE,
        STB_SETUP,
        STB_PULSE,
        STB_WAIT
    } strobe_state_t;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam int unsigned NUM_LINES     = 4;
    localparam int unsigned LINE_W        = 128;

    // DDRAM start address of each display line.
    function automatic logic [7:0] line_addr(input logic [1:0] n);
        case (n)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h10;
            default: return 8'h50;
        endcase
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_DISP_ON;
            2'd2:    return CMD_ENTRY;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_byte_strobe.sv
// Single HD44780 byte transfer: setup cycle, E pulse, then command or clear wait.
// LCD_NUL_AS_SPACE_EN: character bytes equal to 0x00 are sent as 0x20.
module lcd_byte_strobe
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC  = 50,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       ready
);

    localparam int unsigned E_EFF   = at_least_one(E_PULSE_CYC);
    localparam int unsigned CMD_EFF = at_least_one(CMD_WAIT_CYC);
    localparam int unsigned CLR_EFF = at_least_one(CLR_WAIT_CYC);
    localparam int unsigned MAX_CYC = max3(E_EFF, CMD_EFF, CLR_EFF);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    strobe_state_t    state;
    logic [CNT_W-1:0] cnt;
    logic             long_q;
    logic [7:0]       data_xl;
    logic [CNT_W-1:0] wait_last;

`ifdef LCD_NUL_AS_SPACE_EN
    assign data_xl = (rs && (data == 8'h00)) ? 8'h20 : data;
`else
    assign data_xl = data;
`endif

    assign wait_last = long_q ? CNT_W'(CLR_EFF - 1) : CNT_W'(CMD_EFF - 1);

    // rs/data stay on the bus from go until the next go, covering pulse and wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STB_IDLE;
            cnt      <= '0;
            long_q   <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            ready    <= 1'b1;
        end else begin
            case (state)
                STB_IDLE: begin
                    if (go) begin
                        lcd_rs   <= rs;
                        lcd_data <= data_xl;
                        long_q   <= long_wait;
                        ready    <= 1'b0;
                        state    <= STB_SETUP;
                    end
                end
                STB_SETUP: begin
                    lcd_e <= 1'b1;
                    cnt   <= '0;
                    state <= STB_PULSE;
                end
                STB_PULSE: begin
                    if (cnt == CNT_W'(E_EFF - 1)) begin
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                        state <= STB_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STB_WAIT: begin
                    if (cnt == wait_last) begin
                        cnt   <= '0;
                        ready <= 1'b1;
                        state <= STB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= STB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Powers up and initialises an HD44780 4x16 display, then writes latched frames on start.
// LCD_NUL_AS_SPACE_EN (see lcd_byte_strobe) maps NUL characters to spaces.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_PULSE_CYC  = 50,
    parameter int unsigned CMD_WAIT_CYC = 2500,
    parameter int unsigned CLR_WAIT_CYC = 100000,
    parameter int unsigned PWR_WAIT_CYC = 750000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LINE_W-1:0]   line1,
    input  logic [LINE_W-1:0]   line2,
    input  logic [LINE_W-1:0]   line3,
    input  logic [LINE_W-1:0]   line4,
    output logic                busy,
    output logic                done,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [7:0]          lcd_data
);

    localparam int unsigned PWR_EFF = at_least_one(PWR_WAIT_CYC);
    localparam int unsigned PWR_W   = $clog2(PWR_EFF + 1);

    lcd_state_t        state;
    logic [PWR_W-1:0]  pwr_cnt;
    logic [1:0]        init_idx;
    logic [1:0]        line_idx;
    logic [3:0]        char_idx;
    logic [LINE_W-1:0] line_buf [NUM_LINES];
    logic              go;
    logic              pending;
    logic              byte_rs;
    logic [7:0]        byte_data;
    logic              byte_long;
    logic              ready;
    logic              can_issue;
    logic              byte_done;
    logic [LINE_W-1:0] cur_line;
    logic [7:0]        cur_char;

    assign lcd_rw    = 1'b0;
    assign can_issue = !pending && ready && !go;
    assign byte_done = pending && ready && !go;
    assign cur_line  = line_buf[line_idx];
    assign cur_char  = cur_line[{4'd15 - char_idx, 3'b000} +: 8];

    lcd_byte_strobe #(
        .E_PULSE_CYC  (E_PULSE_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_strobe (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .rs        (byte_rs),
        .data      (byte_data),
        .long_wait (byte_long),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_data  (lcd_data),
        .ready     (ready)
    );

    // Sequencer: each state issues one byte via go, then advances when the strobe is ready again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWR_WAIT;
            pwr_cnt   <= '0;
            init_idx  <= '0;
            line_idx  <= '0;
            char_idx  <= '0;
            go        <= 1'b0;
            pending   <= 1'b0;
            byte_rs   <= 1'b0;
            byte_data <= 8'h00;
            byte_long <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            for (int i = 0; i < NUM_LINES; i++) line_buf[i] <= '0;
        end else begin
            go   <= 1'b0;
            done <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (pwr_cnt == PWR_W'(PWR_EFF - 1)) begin
                        pwr_cnt <= '0;
                        state   <= INIT;
                    end else begin
                        pwr_cnt <= pwr_cnt + 1'b1;
                    end
                end
                INIT: begin
                    if (can_issue) begin
                        go        <= 1'b1;
                        pending   <= 1'b1;
                        byte_rs   <= 1'b0;
                        byte_data <= init_cmd(init_idx);
                        byte_long <= (init_idx == 2'd3);
                    end else if (byte_done) begin
                        pending <= 1'b0;
                        if (init_idx == 2'd3) begin
                            init_idx <= '0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                        end
                    end
                end
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    line_buf[0] <= line1;
                    line_buf[1] <= line2;
                    line_buf[2] <= line3;
                    line_buf[3] <= line4;
                    line_idx    <= '0;
                    char_idx    <= '0;
                    state       <= SEND_ADDR;
                end
                SEND_ADDR: begin
                    if (can_issue) begin
                        go        <= 1'b1;
                        pending   <= 1'b1;
                        byte_rs   <= 1'b0;
                        byte_data <= CMD_SET_DDRAM | line_addr(line_idx);
                        byte_long <= 1'b0;
                    end else if (byte_done) begin
                        pending <= 1'b0;
                        state   <= SEND_CHAR;
                    end
                end
                SEND_CHAR: begin
                    if (can_issue) begin
                        go        <= 1'b1;
                        pending   <= 1'b1;
                        byte_rs   <= 1'b1;
                        byte_data <= cur_char;
                        byte_long <= 1'b0;
                    end else if (byte_done) begin
                        pending  <= 1'b0;
                        char_idx <= char_idx + 4'd1;
                        if (char_idx == 4'd15) begin
                            line_idx <= line_idx + 2'd1;
                            if (line_idx == 2'd3) begin
                                done  <= 1'b1;
                                state <= FINISH;
                            end else begin
                                state <= SEND_ADDR;
                            end
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer: init sequence, frame content, start handling, mid-frame reset.
module tb_lcd_frame_writer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] line1, line2, line3, line4;
    logic         busy, done, lcd_e, lcd_rs, lcd_rw;
    logic [7:0]   lcd_data;

    int checks = 0;
    int errors = 0;

    logic [8:0]   cap [$];
    logic         e_prev = 1'b0;
    int           done_cnt = 0;
    logic [127:0] exp_lines [4];

`ifdef LCD_NUL_AS_SPACE_EN
    localparam logic [8:0] NUL_EXP = 9'h120;
`else
    localparam logic [8:0] NUL_EXP = 9'h100;
`endif

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .E_PULSE_CYC  (2),
        .CMD_WAIT_CYC (3),
        .CLR_WAIT_CYC (5),
        .PWR_WAIT_CYC (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .line1    (line1),
        .line2    (line2),
        .line3    (line3),
        .line4    (line4),
        .busy     (busy),
        .done     (done),
        .lcd_e    (lcd_e),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_data (lcd_data)
    );

    // Capture {rs,data} on each falling edge of lcd_e and count done cycles.
    always @(posedge clk) begin
        if (rst) begin
            e_prev <= 1'b0;
        end else begin
            if (e_prev && !lcd_e) cap.push_back({lcd_rs, lcd_data});
            e_prev <= lcd_e;
            if (done === 1'b1) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] cap_at(input int i);
        if (i < cap.size()) return cap[i];
        return 9'h1FF;
    endfunction

    function automatic logic [8:0] exp_byte(input int idx);
        logic [7:0]   addr [4];
        logic [127:0] l;
        logic [7:0]   c;
        int           n, k;
        addr = '{8'h80, 8'hC0, 8'h90, 8'hD0};
        n = idx / 17;
        k = idx % 17;
        if (k == 0) return {1'b0, addr[n]};
        l = exp_lines[n];
        c = l[127 - 8 * (k - 1) -: 8];
`ifdef LCD_NUL_AS_SPACE_EN
        if (c == 8'h00) c = 8'h20;
`endif
        return {1'b1, c};
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_init(input string tag);
        logic [8:0] init_exp [4];
        init_exp = '{9'h038, 9'h00C, 9'h006, 9'h001};
        check({tag, "_count"}, cap.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_byte%0d", tag, i), {23'b0, cap_at(i)}, {23'b0, init_exp[i]});
    endtask

    initial begin
        int n;
        int bad;
        int base_done;

        line1 = '0; line2 = '0; line3 = '0; line4 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_lcd_e", {31'b0, lcd_e}, 32'd0);
        check("rst_lcd_rs", {31'b0, lcd_rs}, 32'd0);
        check("rst_lcd_rw", {31'b0, lcd_rw}, 32'd0);
        check("rst_lcd_data", {24'b0, lcd_data}, 32'd0);

        // Power-on wait: bus quiet and busy for the first 10 cycles.
        cap.delete();
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (lcd_e !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("pwr_wait_quiet", bad, 32'd0);
        wait_idle("init_idle", 2000);
        check_init("init");

        // Frame 1: right-aligned text with leading NULs, line1 changed after LATCH, extra start while busy.
        line1 = {24'h0, "ADD RD1:+RD2:"};
        line2 = "0123456789ABCDEF";
        line3 = '0;
        line4 = "hd44780 frame ok";
        exp_lines = '{line1, line2, line3, line4};
        cap.delete();
        base_done = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_accepted", {31'b0, busy}, 32'd1);
        @(negedge clk);
        line1 = {16{8'h58}};
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("frame1_idle", 3000);
        repeat (20) @(negedge clk);
        check("frame1_done_pulses", done_cnt - base_done, 32'd1);
        check("frame1_count", cap.size(), 32'd68);
        check("frame1_addr_l1", {23'b0, cap_at(0)}, 32'h080);
        check("frame1_nul0", {23'b0, cap_at(1)}, {23'b0, NUL_EXP});
        check("frame1_nul2", {23'b0, cap_at(3)}, {23'b0, NUL_EXP});
        check("frame1_char_A", {23'b0, cap_at(4)}, 32'h141);
        check("frame1_char_D", {23'b0, cap_at(5)}, 32'h144);
        check("frame1_addr_l2", {23'b0, cap_at(17)}, 32'h0C0);
        check("frame1_l2_c0", {23'b0, cap_at(18)}, 32'h130);
        check("frame1_addr_l3", {23'b0, cap_at(34)}, 32'h090);
        check("frame1_addr_l4", {23'b0, cap_at(51)}, 32'h0D0);
        check("frame1_last", {23'b0, cap_at(67)}, 32'h16B);
        for (int i = 0; i < 68; i++)
            check($sformatf("frame1_byte%0d", i), {23'b0, cap_at(i)}, {23'b0, exp_byte(i)});

        // Frame 2: start raised in the done cycle is dropped, accepted one cycle later.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("frame2_done_seen", {31'b0, done}, 32'd1);
        start = 1'b1;
        @(negedge clk);
        check("start_on_done_ignored", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("start_after_done_accepted", {31'b0, busy}, 32'd1);
        start = 1'b0;

        // Frame 3 is interrupted by reset while lcd_e is high.
        cap.delete();
        n = 0;
        while (!(lcd_e === 1'b1 && cap.size() >= 10) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("midframe_e_high", {31'b0, lcd_e}, 32'd1);
        base_done = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lcd_e", {31'b0, lcd_e}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd1);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_lcd_data", {24'b0, lcd_data}, 32'd0);
        check("midrst_lcd_rs", {31'b0, lcd_rs}, 32'd0);
        repeat (2) @(negedge clk);
        cap.delete();
        rst = 1'b0;
        wait_idle("reinit_idle", 2000);
        check_init("reinit");
        repeat (10) @(negedge clk);
        check("no_done_after_reset", done_cnt - base_done, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
LCD_FRAME_WRITER -- requirements
Module: lcd_frame_writer

Interface
REQ-001 Parameter E_PULSE_CYC, default 50: number of clk cycles lcd_e is held high per byte.
REQ-002 Parameter CMD_WAIT_CYC, default 2500: clk cycles waited after lcd_e falls, before the next byte.
REQ-003 Parameter CLR_WAIT_CYC, default 100000: wait after the clear command (0x01), replacing CMD_WAIT_CYC.
REQ-004 Parameter PWR_WAIT_CYC, default 750000: power-on wait before the first init command.
REQ-005 clk  in  1  single clock; all logic is on the posedge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  frame request pulse; sampled only in IDLE.
REQ-008 line1..line4  in  128 each  16 ASCII chars per line; char k (0 = leftmost) is at bits [127-8k -: 8].
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse when a frame completes.
REQ-011 lcd_e, lcd_rs, lcd_rw  out  1 each  HD44780 strobe, register select (1 = data), and read/write (tied 0).
REQ-012 lcd_data  out  8  8-bit HD44780 data bus.

Function
REQ-013 FSM states are PWR_WAIT, INIT, IDLE, LATCH, SEND_ADDR, SEND_CHAR and FINISH.
REQ-014 On leaving reset, the FSM enters PWR_WAIT, counts PWR_WAIT_CYC cycles, then enters INIT.
REQ-015 INIT sends commands 0x38, 0x0C, 0x06 and 0x01 in order, then enters IDLE.
REQ-016 Each byte transfer works as follows:
- lcd_rs and lcd_data are set and held stable for the whole transfer, including the wait.
- lcd_e goes high 1 cycle later and stays high for E_PULSE_CYC cycles.
- lcd_e then goes low, followed by the wait.
REQ-017 In IDLE with start=1, the FSM enters LATCH, which copies line1..line4 into internal buffers in that cycle; later input changes do not affect the frame.
REQ-018 For each line n=0..3, the FSM does the following:
- SEND_ADDR sends command 0x80|A[n], with A = {0x00, 0x40, 0x10, 0x50}.
- SEND_CHAR then sends chars 0..15 with rs=1.
REQ-019 A frame is 68 bytes; after the last char of line 4, FINISH pulses done for 1 cycle and returns to IDLE.
REQ-020 Character index and line counters wrap 15→0 and 3→0 respectively.
REQ-021 start is ignored while busy=1 and is not queued.
REQ-022 start=1 in the same cycle as done returns to IDLE is ignored; it is accepted on the next cycle.
REQ-023 Wait counters are wide enough for the largest parameter, and a counter value of 0 is treated as 1.

Reset
REQ-024 rst=1 at any cycle, including mid-byte, forces the following values on the next edge:
- state PWR_WAIT, all counters 0;
- lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00;
- busy=1, done=0;
- buffers cleared to 0.
REQ-025 The init sequence is always re-run after reset.

Configuration
REQ-026 Macro LCD_NUL_AS_SPACE_EN applies only to character bytes (rs=1):
- defined: a byte equal to 0x00 is sent as 0x20;
- undefined: bytes are sent unmodified.
Commands are never translated.

Structure
REQ-027 Package lcd_pkg holds:
- the FSM state enum;
- the command constants 0x38, 0x0C, 0x06, 0x01 and 0x80;
- the line address table A.
REQ-028 One sub-module, lcd_byte_strobe, performs a single byte transfer with timing per REQ-016 and a clear-wait select:
- inputs: go, rs, data, long_wait;
- outputs: lcd_e, lcd_rs, lcd_data, ready.

Verification
REQ-029 Benches use E_PULSE_CYC=2, CMD_WAIT_CYC=3, CLR_WAIT_CYC=5 and PWR_WAIT_CYC=10.
REQ-030 Reset release -> after 10 cycles, bytes 0x38, 0x0C, 0x06, 0x01 are captured on the lcd_e falling edge, all with rs=0; then busy=0.
REQ-031 start with line1 = "ADD RD1:+RD2:" right-aligned (3 leading 0x00), other lines 0 -> capture shows:
- 0x80, then 0x20 ×3, then 0x41 0x44 0x44 … (macro defined);
- 0xC0 before line 2;
- exactly 68 bytes, then done=1 for 1 cycle.
REQ-032 The same stimulus with the macro undefined -> the first three chars of line 1 are 0x00.
REQ-033 line1 is changed in the cycle after LATCH -> captured bytes match the latched value.
REQ-034 A second start while busy=1 is ignored -> exactly one done pulse and 68 bytes.
REQ-035 rst asserted while lcd_e=1 mid-frame -> next cycle lcd_e=0 and busy=1; init is repeated; no done pulse.
